// File: rtl/bcd_countdown.sv
// Four-digit BCD countdown timer with start/pause and restart pushbuttons, a preset register and expiry LED.
// Optional MMSS_MODE_EN build makes BCD1/BCD3 tens-of-seconds/minutes digits (0-5).
module bcd_countdown #(
    parameter int TICK_DIV = 25000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Pushbutton1,
    input  logic        Pushbutton2,
    input  logic        Load,
    input  logic [15:0] Preset,
    output logic [3:0]  BCD0,
    output logic [3:0]  BCD1,
    output logic [3:0]  BCD2,
    output logic [3:0]  BCD3,
    output logic        LED,
    output logic        Running,
    output logic [1:0]  state_dbg
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

`ifdef MMSS_MODE_EN
    localparam logic [3:0] TENS_MAX = 4'd5;
`else
    localparam logic [3:0] TENS_MAX = 4'd9;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     digits_q, digits_d;
    logic [15:0]     preset_q, preset_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            led_q, led_d;
    logic [2:0]      pb1_sync_q, pb1_sync_d;
    logic [2:0]      pb2_sync_q, pb2_sync_d;

    logic            pb1_press;
    logic            pb2_press;
    logic [15:0]     preset_clamped;
    logic [15:0]     digits_dec;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // Borrow ripples upward; a tens digit wraps to TENS_MAX, the others to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [15:0] r;
        logic        borrow;
        logic [3:0]  dig;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig = d[i*4 +: 4];
            if (borrow) begin
                if (dig == 4'd0) begin
                    r[i*4 +: 4] = (i == 1 || i == 3) ? TENS_MAX : 4'd9;
                end else begin
                    r[i*4 +: 4] = dig - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two synchroniser stages plus one history flop: a falling pin acts on the third edge.
    assign pb1_sync_d = {pb1_sync_q[1:0], Pushbutton1};
    assign pb2_sync_d = {pb2_sync_q[1:0], Pushbutton2};
    assign pb1_press  = pb1_sync_q[2] & ~pb1_sync_q[1];
    assign pb2_press  = pb2_sync_q[2] & ~pb2_sync_q[1];

    assign preset_clamped = {clamp_digit(Preset[15:12], TENS_MAX),
                             clamp_digit(Preset[11:8],  4'd9),
                             clamp_digit(Preset[7:4],   TENS_MAX),
                             clamp_digit(Preset[3:0],   4'd9)};
    assign digits_dec = bcd_dec(digits_q);

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        preset_d = preset_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        if (Load) begin
            preset_d = preset_clamped;
            digits_d = preset_clamped;
            state_d  = IDLE;
            led_d    = 1'b0;
            cnt_d    = '0;
        end else if (pb2_press) begin
            digits_d = preset_q;
            state_d  = IDLE;
            led_d    = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pb1_press) begin
                        if (digits_q == 16'h0000) begin
                            state_d = DONE;
                            led_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end
                    end
                end
                RUN: begin
                    if (pb1_press) begin
                        state_d = PAUSE;
                    end else if (cnt_q == TICK_LAST) begin
                        cnt_d    = '0;
                        digits_d = digits_dec;
                        if (digits_dec == 16'h0000) begin
                            state_d = DONE;
                            led_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAUSE: begin
                    // Resume keeps the partially elapsed tick count.
                    if (pb1_press) begin
                        if (digits_q == 16'h0000) begin
                            state_d = DONE;
                            led_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            digits_q   <= '0;
            preset_q   <= '0;
            cnt_q      <= '0;
            led_q      <= 1'b0;
            pb1_sync_q <= 3'b111;
            pb2_sync_q <= 3'b111;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            preset_q   <= preset_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            pb1_sync_q <= pb1_sync_d;
            pb2_sync_q <= pb2_sync_d;
        end
    end

    assign BCD0      = digits_q[3:0];
    assign BCD1      = digits_q[7:4];
    assign BCD2      = digits_q[11:8];
    assign BCD3      = digits_q[15:12];
    assign LED       = led_q;
    assign Running   = (state_q == RUN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown at TICK_DIV=4; expectations follow MMSS_MODE_EN when defined.
module tb_bcd_countdown;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Pushbutton1;
    logic        Pushbutton2;
    logic        Load;
    logic [15:0] Preset;
    logic [3:0]  BCD0, BCD1, BCD2, BCD3;
    logic        LED;
    logic        Running;
    logic [1:0]  state_dbg;
    logic [15:0] digits;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef MMSS_MODE_EN
    localparam logic [15:0] EXP_1000 = 16'h0959;
    localparam logic [15:0] EXP_AF   = 16'h0059;
`else
    localparam logic [15:0] EXP_1000 = 16'h0999;
    localparam logic [15:0] EXP_AF   = 16'h0099;
`endif

    int checks = 0;
    int errors = 0;

    bcd_countdown #(.TICK_DIV(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Pushbutton1(Pushbutton1),
        .Pushbutton2(Pushbutton2),
        .Load       (Load),
        .Preset     (Preset),
        .BCD0       (BCD0),
        .BCD1       (BCD1),
        .BCD2       (BCD2),
        .BCD3       (BCD3),
        .LED        (LED),
        .Running    (Running),
        .state_dbg  (state_dbg)
    );

    assign digits = {BCD3, BCD2, BCD1, BCD0};

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Returns 1ns after the edge on which the press takes effect.
    task automatic press1();
        Pushbutton1 = 1'b0;
        step(1);
        Pushbutton1 = 1'b1;
        step(2);
    endtask

    task automatic press2();
        Pushbutton2 = 1'b0;
        step(1);
        Pushbutton2 = 1'b1;
        step(2);
    endtask

    task automatic do_load(input logic [15:0] value);
        Load   = 1'b1;
        Preset = value;
        step(1);
        Load   = 1'b0;
    endtask

    initial begin
        Reset       = 1'b0;
        Pushbutton1 = 1'b1;
        Pushbutton2 = 1'b1;
        Load        = 1'b0;
        Preset      = 16'h0000;

        #2;
        check("reset_digits", digits, 16'h0000);
        check("reset_led", LED, 1'b0);
        check("reset_running", Running, 1'b0);
        check("reset_state", state_dbg, S_IDLE);
        step(2);
        Reset = 1'b1;
        step(2);
        check("post_reset_digits", digits, 16'h0000);
        check("post_reset_state", state_dbg, S_IDLE);

        // Basic countdown 0012 -> 0011 -> 0010 -> 0009
        do_load(16'h0012);
        check("load12_digits", digits, 16'h0012);
        check("load12_state", state_dbg, S_IDLE);
        check("load12_running", Running, 1'b0);
        press1();
        check("start_running", Running, 1'b1);
        check("start_state", state_dbg, S_RUN);
        step(3);
        check("before_tick1", digits, 16'h0012);
        step(1);
        check("tick1", digits, 16'h0011);
        step(4);
        check("tick2", digits, 16'h0010);
        step(4);
        check("tick3_borrow", digits, 16'h0009);

        // Pause with tick counter at 2, resume -> decrement 2 cycles later
        press1();
        check("pause_state", state_dbg, S_PAUSE);
        check("pause_running", Running, 1'b0);
        check("pause_digits", digits, 16'h0009);
        step(20);
        check("pause_hold", digits, 16'h0009);
        press1();
        check("resume_state", state_dbg, S_RUN);
        check("resume_digits", digits, 16'h0009);
        step(1);
        check("resume_plus1", digits, 16'h0009);
        step(1);
        check("resume_plus2", digits, 16'h0008);

        // Restart from PAUSE
        press1();
        check("pause2_state", state_dbg, S_PAUSE);
        press2();
        check("pb2_restore", digits, 16'h0012);
        check("pb2_state", state_dbg, S_IDLE);
        check("pb2_running", Running, 1'b0);

        // Load and PB2 acting on the same edge, with clamping
        Pushbutton2 = 1'b0;
        step(1);
        Pushbutton2 = 1'b1;
        step(1);
        do_load(16'h00AF);
        check("load_wins_digits", digits, EXP_AF);
        check("load_wins_state", state_dbg, S_IDLE);
        press2();
        check("clamped_preset_reg", digits, EXP_AF);

        // Multi-digit borrow
        do_load(16'h1000);
        press1();
        step(3);
        check("pre_borrow", digits, 16'h1000);
        step(1);
        check("borrow_chain", digits, EXP_1000);

        // Load in RUN, then a held button acts only once, 3 edges after the fall
        do_load(16'h0005);
        check("load_in_run_state", state_dbg, S_IDLE);
        Pushbutton1 = 1'b0;
        step(2);
        check("press_latency2", Running, 1'b0);
        step(1);
        check("press_latency3", Running, 1'b1);
        step(5);
        check("held_once_a", Running, 1'b1);
        Pushbutton1 = 1'b1;
        step(3);
        check("held_once_b", state_dbg, S_RUN);
        check("held_digits", digits, 16'h0003);

        // Run to expiry
        do_load(16'h0002);
        press1();
        step(4);
        check("expiry_tick1", digits, 16'h0001);
        check("expiry_tick1_run", Running, 1'b1);
        step(3);
        check("expiry_pre", digits, 16'h0001);
        check("expiry_pre_led", LED, 1'b0);
        step(1);
        check("expiry_digits", digits, 16'h0000);
        check("expiry_led", LED, 1'b1);
        check("expiry_running", Running, 1'b0);
        check("expiry_state", state_dbg, S_DONE);
        press1();
        check("done_ignore_state", state_dbg, S_DONE);
        check("done_ignore_led", LED, 1'b1);
        step(10);
        check("done_hold_digits", digits, 16'h0000);
        press2();
        check("done_pb2_digits", digits, 16'h0002);
        check("done_pb2_led", LED, 1'b0);
        check("done_pb2_state", state_dbg, S_IDLE);

        // Start with 0000 goes straight to DONE
        do_load(16'h0000);
        press1();
        check("zero_start_state", state_dbg, S_DONE);
        check("zero_start_led", LED, 1'b1);
        check("zero_start_running", Running, 1'b0);

        // Asynchronous reset during RUN
        do_load(16'h0050);
        press1();
        step(2);
        Reset = 1'b0;
        #2;
        check("async_reset_digits", digits, 16'h0000);
        check("async_reset_running", Running, 1'b0);
        check("async_reset_led", LED, 1'b0);
        check("async_reset_state", state_dbg, S_IDLE);
        step(1);
        Reset = 1'b1;
        step(3);
        check("after_reset_digits", digits, 16'h0000);
        check("after_reset_state", state_dbg, S_IDLE);
        step(10);
        check("after_reset_hold", digits, 16'h0000);
        do_load(16'h0012);
        check("after_reset_load", digits, 16'h0012);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clock cycles per one-second decrement tick (minimum 2).
REQ-002 SHALL have port Clock, input, 1, the single system clock; all state on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Pushbutton1, input, 1, active-low start/pause toggle, externally debounced, asynchronous to Clock.
REQ-005 SHALL have port Pushbutton2, input, 1, active-low restart: reload the stored preset, externally debounced.
REQ-006 SHALL have port Load, input, 1, active-high synchronous preset load strobe.
REQ-007 SHALL have port Preset, input, 16, four BCD digits; [3:0] is digit 0 (least significant).
REQ-008 SHALL have ports BCD0, BCD1, BCD2, BCD3, output, 4 each, current count digits; BCD0 is least significant.
REQ-009 SHALL have port LED, output, 1, expiry indicator.
REQ-010 SHALL have port Running, output, 1, high only in state RUN.

Function
REQ-011 SHALL synchronise Pushbutton1/2 through two flops, then detect a 1->0 edge; a press SHALL act exactly once, 3 Clock edges after the pin falls.
REQ-012 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-013 SHALL transition IDLE->RUN, RUN->PAUSE, and PAUSE->RUN on a Pushbutton1 press; a press in DONE SHALL be ignored.
REQ-014 SHALL go to DONE on the edge after a Pushbutton1 press from IDLE or PAUSE when the count is 0000, setting LED to 1, never entering RUN.
REQ-015 SHALL capture Preset into an internal preset register on Load, copy it to the digits, enter IDLE, clear LED, and clear the tick counter, in any state.
REQ-016 SHALL clamp any Load digit >9 to 9, in both the preset register and the outputs.
REQ-017 SHALL, on a Pushbutton2 press, copy the preset register to the digits, enter IDLE, clear LED, and clear the tick counter.
REQ-018 SHALL apply priority Load > Pushbutton2 > Pushbutton1 when events coincide on the same edge.
REQ-019 SHALL advance the tick counter 0..TICK_DIV-1 only in RUN; it SHALL hold in PAUSE and be zeroed on entering RUN from IDLE.
REQ-020 SHALL generate a one-cycle tick when the counter equals TICK_DIV-1, wrapping it to 0; the first decrement after a start occurs TICK_DIV cycles after RUN entry.
REQ-021 SHALL decrement the 4-digit BCD count by one per tick: a digit at 0 becomes 9 and borrows from the next digit; other digits are unaffected.
REQ-022 SHALL, on the tick that brings the count to 0000, update the digits to 0000, enter DONE, and set LED to 1, all on that same edge.
REQ-023 SHALL hold the digits at 0000 and LED at 1 in DONE until Load, Pushbutton2, or Reset.
REQ-024 SHALL never produce a digit value >9 on BCD0..BCD3.

Reset
REQ-025 SHALL, while Reset is low, asynchronously force: state IDLE; BCD0..BCD3 = 0; preset register = 0; tick counter = 0; LED = 0; Running = 0; synchroniser flops = 1.
REQ-026 SHALL abort any count when Reset is asserted mid-RUN, and resume only on a fresh Pushbutton1 press after release.
REQ-027 SHALL treat Reset release as synchronous to Clock, with no press detected on the release edge.

Configuration
REQ-028 SHALL, when MMSS_MODE_EN is defined, treat BCD1 and BCD3 as tens digits (range 0-5): the borrow into BCD1 yields 5 (not 9), and Load clamps BCD1/BCD3 digits >5 to 5.
REQ-029 SHALL, when MMSS_MODE_EN is undefined, treat all four digits as 0-9 decimal (0000-9999).

Verification (TICK_DIV=4)
REQ-030 SHALL verify: Load Preset=16'h0012, press PB1 -> digits 0011, 0010, 0009 at 4-cycle intervals after RUN entry.
REQ-031 SHALL verify: Preset 0002, start, run to end -> digits 0000, LED=1, Running=0 on the same edge as the final tick; further PB1 presses ignored.
REQ-032 SHALL verify: Preset 1000, one tick -> 0999 without MMSS_MODE_EN, and 0959 with MMSS_MODE_EN defined.
REQ-033 SHALL verify: Preset 16'h00AF -> digits 0099 (0059 with MMSS_MODE_EN); Load and PB2 on the same edge -> Load wins.
REQ-034 SHALL verify: pause mid-count at tick counter=2, wait 20 cycles, resume -> next decrement 2 cycles later; PB2 in PAUSE -> preset restored, IDLE.
REQ-035 SHALL verify: Reset low during RUN -> all outputs 0 immediately (before the next Clock edge); after release, digits hold 0000 until Load.
